// File: rtl/mem_port_pkg.sv
// Shared types for the data-memory port scheduler.
// Build option: MEM_PORT_CTRL_STATS_EN adds grant/conflict counters.
package mem_port_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef struct packed {
    logic       valid;
    logic       port;
    logic       we;
    size_e      size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } resp_tag_t;

  function automatic logic misaligned(size_e s, logic [1:0] off);
    logic e;
    unique case (s)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Fetch, load/store and memory-side signals of the port scheduler.
// slave = scheduler view, master = core/memory view.
interface mem_port_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_size, d_unsigned,
    input  d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_raddr, mem_waddr,
    output mem_wdata, mem_wr,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_size, d_unsigned,
    output d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_raddr, mem_waddr,
    input  mem_wdata, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_ctrl_load_align.sv
// Load lane extraction with sign/zero extension.
// Misaligned sizes never reach here with a valid response.
module mem_load_align
  import mem_port_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  assign lane8  = word[{off, 3'b000} +: 8];
  assign lane16 = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    result = word;
    unique case (size)
      SZ_BYTE: result = {{24{~uns & lane8[7]}}, lane8};
      SZ_HALF: result = {{16{~uns & lane16[15]}}, lane16};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Fetch vs load/store scheduler for the four-bank byte-lane memory.
// Build option: MEM_PORT_CTRL_STATS_EN adds stat_* counter outputs.
module mem_port_ctrl
  import mem_port_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input logic Clk,
  input logic Reset,
  mem_port_ctrl_if.slave bus
`ifdef MEM_PORT_CTRL_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_conflicts
`endif
);

  logic        rrLast;
  logic        ifGnt;
  logic        dGnt;
  size_e       dSize;
  logic [1:0]  off;
  logic        dErr;
  logic [31:0] addrSel;
  logic [31:0] laneData;
  logic [3:0]  laneMask;
  resp_tag_t   newTag;
  resp_tag_t   outTag;
  resp_tag_t   tagQ [RD_LATENCY];
  logic [31:0] loadData;

  assign dSize = size_e'(bus.d_size);
  assign off   = bus.d_addr[1:0];
  assign dErr  = misaligned(dSize, off);

  // Conflicts go to whichever port was not granted last.
  always_comb begin
    ifGnt = 1'b0;
    dGnt  = 1'b0;
    if (!Reset) begin
      unique case (1'b1)
        bus.if_req && bus.d_req: begin
          ifGnt = (rrLast == PORT_D);
          dGnt  = (rrLast == PORT_IF);
        end
        bus.if_req && !bus.d_req: ifGnt = 1'b1;
        !bus.if_req && bus.d_req: dGnt  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.if_gnt = ifGnt;
  assign bus.d_gnt  = dGnt;

  assign addrSel       = dGnt ? bus.d_addr : bus.if_addr;
  assign bus.mem_raddr = addrSel & ~32'h3;
  assign bus.mem_waddr = addrSel & ~32'h3;

  always_comb begin
    laneData = bus.d_wdata;
    laneMask = 4'b1111;
    unique case (dSize)
      SZ_BYTE: begin
        laneData = {4{bus.d_wdata[7:0]}};
        laneMask = 4'b0001 << off;
      end
      SZ_HALF: begin
        laneData = {2{bus.d_wdata[15:0]}};
        laneMask = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  assign bus.mem_wdata = laneData;
  assign bus.mem_wr    = (dGnt && bus.d_we && !dErr) ? laneMask : 4'b0000;

  always_comb begin
    newTag       = '0;
    newTag.valid = ifGnt | dGnt;
    newTag.port  = dGnt ? PORT_D : PORT_IF;
    newTag.we    = dGnt & bus.d_we;
    newTag.size  = dSize;
    newTag.uns   = bus.d_unsigned;
    newTag.off   = off;
    newTag.err   = dGnt & dErr;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rrLast <= PORT_D;
      for (int i = 0; i < RD_LATENCY; i++) tagQ[i] <= '0;
    end else begin
      tagQ[0] <= newTag;
      for (int i = 1; i < RD_LATENCY; i++) tagQ[i] <= tagQ[i-1];
      if (ifGnt || dGnt) rrLast <= dGnt ? PORT_D : PORT_IF;
    end
  end

  assign outTag = tagQ[RD_LATENCY-1];

  mem_load_align u_align (
    .size   (outTag.size),
    .uns    (outTag.uns),
    .off    (outTag.off),
    .word   (bus.mem_rdata),
    .result (loadData)
  );

  assign bus.if_rvalid = outTag.valid && (outTag.port == PORT_IF);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.d_rvalid  = outTag.valid && (outTag.port == PORT_D);
  assign bus.d_err     = bus.d_rvalid && outTag.err;
  assign bus.d_rdata   = (bus.d_rvalid && !outTag.we && !outTag.err)
                         ? loadData : 32'h0;

`ifdef MEM_PORT_CTRL_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (ifGnt) stat_if_grants <= stat_if_grants + 32'd1;
      if (dGnt)  stat_d_grants  <= stat_d_grants + 32'd1;
      if (bus.if_req && bus.d_req)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench: one DUT at RD_LATENCY=1, one at 2, same stimulus.
// Build option: MEM_PORT_CTRL_STATS_EN also checks the counters.
module tb_mem_port_ctrl;
  import mem_port_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 Clk = ~Clk;

  mem_port_ctrl_if bus1();
  mem_port_ctrl_if bus2();

  assign bus2.if_req     = bus1.if_req;
  assign bus2.if_addr    = bus1.if_addr;
  assign bus2.d_req      = bus1.d_req;
  assign bus2.d_we       = bus1.d_we;
  assign bus2.d_size     = bus1.d_size;
  assign bus2.d_unsigned = bus1.d_unsigned;
  assign bus2.d_addr     = bus1.d_addr;
  assign bus2.d_wdata    = bus1.d_wdata;

`ifdef MEM_PORT_CTRL_STATS_EN
  logic [31:0] sIf1, sD1, sC1, sIf2, sD2, sC2;
`endif

  mem_port_ctrl #(.RD_LATENCY(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1)
`ifdef MEM_PORT_CTRL_STATS_EN
    ,
    .stat_if_grants (sIf1),
    .stat_d_grants  (sD1),
    .stat_conflicts (sC1)
`endif
  );

  mem_port_ctrl #(.RD_LATENCY(2)) dut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus2)
`ifdef MEM_PORT_CTRL_STATS_EN
    ,
    .stat_if_grants (sIf2),
    .stat_d_grants  (sD2),
    .stat_conflicts (sC2)
`endif
  );

  // Memory models: word i starts as 0xC0DE0000|i, writes on the edge.
  logic [31:0] m1 [256];
  logic [31:0] m2 [256];
  logic [31:0] p1, p2a, p2b;

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) begin
        m1[i] <= 32'hC0DE0000 | i;
        m2[i] <= 32'hC0DE0000 | i;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus1.mem_wr[b])
          m1[bus1.mem_waddr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
        if (bus2.mem_wr[b])
          m2[bus2.mem_waddr[9:2]][8*b +: 8] <= bus2.mem_wdata[8*b +: 8];
      end
    end
    p1  <= m1[bus1.mem_raddr[9:2]];
    p2a <= m2[bus2.mem_raddr[9:2]];
    p2b <= p2a;
  end

  assign bus1.mem_rdata = p1;
  assign bus2.mem_rdata = p2b;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic dop(input string nm, input logic we,
                     input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] expWr,
                     input logic [31:0] expWdata,
                     input logic [31:0] expRdata,
                     input logic expErr);
    @(negedge Clk);
    bus1.d_req      = 1'b1;
    bus1.d_we       = we;
    bus1.d_size     = sz;
    bus1.d_unsigned = uns;
    bus1.d_addr     = addr;
    bus1.d_wdata    = wdata;
    #1;
    chk({nm, "_gnt"}, bus1.d_gnt, 1);
    chk({nm, "_memwr"}, bus1.mem_wr, expWr);
    chk({nm, "_waddr"}, bus1.mem_waddr, addr & ~32'h3);
    if (expWr != 4'b0000) chk({nm, "_wdata"}, bus1.mem_wdata, expWdata);
    @(negedge Clk);
    bus1.d_req = 1'b0;
    #1;
    chk({nm, "_rv1"}, bus1.d_rvalid, 1);
    chk({nm, "_rd1"}, bus1.d_rdata, expRdata);
    chk({nm, "_err1"}, bus1.d_err, expErr);
    chk({nm, "_rv2early"}, bus2.d_rvalid, 0);
    @(negedge Clk);
    #1;
    chk({nm, "_rv2"}, bus2.d_rvalid, 1);
    chk({nm, "_rd2"}, bus2.d_rdata, expRdata);
    chk({nm, "_err2"}, bus2.d_err, expErr);
    chk({nm, "_rv1late"}, bus1.d_rvalid, 0);
  endtask

  initial begin
    int ifCnt = 0;
    int dCnt = 0;
    int j;
    bus1.if_req     = 1'b1;
    bus1.if_addr    = 32'h200;
    bus1.d_req      = 1'b1;
    bus1.d_we       = 1'b1;
    bus1.d_size     = 2'b10;
    bus1.d_unsigned = 1'b0;
    bus1.d_addr     = 32'h300;
    bus1.d_wdata    = 32'hDEADBEEF;

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_ifgnt", bus1.if_gnt, 0);
    chk("rst_dgnt", bus1.d_gnt, 0);
    chk("rst_memwr", bus1.mem_wr, 0);
    chk("rst_ifrv", bus1.if_rvalid, 0);
    chk("rst_drv", bus1.d_rvalid, 0);
    chk("rst_derr", bus1.d_err, 0);
    chk("rst_drdata", bus1.d_rdata, 0);
    chk("rst_ifrdata", bus1.if_rdata, 0);
    chk("rst2_dgnt", bus2.d_gnt, 0);

    // Continuous conflict: fetch first, then strict alternation.
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      Reset = 1'b0;
      bus1.d_we = 1'b0;
      bus1.if_addr = 32'h200 + 32'(4 * ((k + 1) / 2));
      if (k >= 10) begin
        bus1.if_req = 1'b0;
        bus1.d_req  = 1'b0;
      end
      #1;
      if (k < 10) begin
        chk("alt_ifgnt", bus1.if_gnt, 32'(k % 2 == 0));
        chk("alt_dgnt", bus1.d_gnt, 32'(k % 2 == 1));
        chk("alt2_ifgnt", bus2.if_gnt, 32'(k % 2 == 0));
      end
      ifCnt += int'(bus1.if_gnt);
      dCnt  += int'(bus1.d_gnt);
      j = k - 1;
      chk("l1_ifrv", bus1.if_rvalid, 32'(j >= 0 && j < 10 && j % 2 == 0));
      chk("l1_drv", bus1.d_rvalid, 32'(j >= 0 && j < 10 && j % 2 == 1));
      if (j >= 0 && j < 10 && j % 2 == 0)
        chk("l1_ifrdata", bus1.if_rdata, 32'hC0DE0080 + 32'(j / 2));
      if (j >= 0 && j < 10 && j % 2 == 1)
        chk("l1_drdata", bus1.d_rdata, 32'hC0DE00C0);
      j = k - 2;
      chk("l2_ifrv", bus2.if_rvalid, 32'(j >= 0 && j < 10 && j % 2 == 0));
      chk("l2_drv", bus2.d_rvalid, 32'(j >= 0 && j < 10 && j % 2 == 1));
      if (j >= 0 && j < 10 && j % 2 == 0)
        chk("l2_ifrdata", bus2.if_rdata, 32'hC0DE0080 + 32'(j / 2));
      if (j >= 0 && j < 10 && j % 2 == 1)
        chk("l2_drdata", bus2.d_rdata, 32'hC0DE00C0);
    end
    chk("cnt_if", ifCnt, 5);
    chk("cnt_d", dCnt, 5);
`ifdef MEM_PORT_CTRL_STATS_EN
    chk("stat_if", sIf1, 5);
    chk("stat_d", sD1, 5);
    chk("stat_conf", sC1, 10);
`endif

    // Word 0x100 starts as 0xC0DE0040.
    dop("sb", 1, 2'b00, 0, 32'h103, 32'hAB, 4'b1000, 32'hABABABAB, 0, 0);
    dop("lb", 0, 2'b00, 0, 32'h103, 0, 4'b0000, 0, 32'hFFFFFFAB, 0);
    dop("lbu", 0, 2'b00, 1, 32'h103, 0, 4'b0000, 0, 32'h000000AB, 0);
    dop("sh", 1, 2'b01, 0, 32'h102, 32'h8001, 4'b1100, 32'h80018001, 0, 0);
    dop("lh", 0, 2'b01, 0, 32'h102, 0, 4'b0000, 0, 32'hFFFF8001, 0);
    dop("lhu", 0, 2'b01, 1, 32'h102, 0, 4'b0000, 0, 32'h00008001, 0);
    dop("sw", 1, 2'b10, 0, 32'h100, 32'h12345678, 4'b1111,
        32'h12345678, 0, 0);
    dop("lw", 0, 2'b10, 0, 32'h100, 0, 4'b0000, 0, 32'h12345678, 0);
    dop("lbo1", 0, 2'b00, 0, 32'h101, 0, 4'b0000, 0, 32'h00000056, 0);
    dop("lho2", 0, 2'b01, 0, 32'h102, 0, 4'b0000, 0, 32'h00001234, 0);
    dop("lwmis", 0, 2'b10, 0, 32'h101, 0, 4'b0000, 0, 0, 1);
    dop("shmis", 1, 2'b01, 0, 32'h103, 32'hFFFF, 4'b0000, 0, 0, 1);
    dop("illsz", 0, 2'b11, 0, 32'h100, 0, 4'b0000, 0, 0, 1);
    dop("swill", 1, 2'b11, 0, 32'h100, 32'h0, 4'b0000, 0, 0, 1);
    dop("lwkeep", 0, 2'b10, 0, 32'h100, 0, 4'b0000, 0, 32'h12345678, 0);

    // Reset right after a load fires drops its response.
    @(negedge Clk);
    bus1.d_req  = 1'b1;
    bus1.d_we   = 1'b0;
    bus1.d_size = 2'b10;
    bus1.d_addr = 32'h100;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    bus1.d_req = 1'b0;
    #1;
    chk("mid_rv1", bus1.d_rvalid, 0);
    chk("mid_rv2", bus2.d_rvalid, 0);
`ifdef MEM_PORT_CTRL_STATS_EN
    chk("mid_stat_if", sIf2, 0);
    chk("mid_stat_d", sD2, 0);
    chk("mid_stat_conf", sC2, 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      #1;
      chk("post_rv1", bus1.d_rvalid, 0);
      chk("post_rv2", bus2.d_rvalid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Single-port scheduler for the four-bank byte-lane data memory: arbitrates between the instruction-fetch port and the load/store port, issues one access per cycle, and returns each read after the memory's fixed read latency. Translates RISC-V byte, halfword and word accesses into word-aligned bank addresses, byte-lane write enables and lane-replicated write data. Extracts and sign- or zero-extends load data. Sits between the core pipeline and the memory wrapper.

## Interface
- RD_LATENCY, 1, memory read latency in cycles (legal 1..2)
- Clk  in  1  clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held with fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  zero-extend load (LBU/LHU)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (loads and stores)
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  qualifies d_rvalid: misaligned or illegal size
- mem_raddr  out  32  to memory read address, bits [1:0] always 00
- mem_waddr  out  32  to memory write address, bits [1:0] always 00
- mem_wdata  out  32  lane-replicated store data
- mem_wr  out  4  per-lane write enable
- mem_rdata  in  32  memory read data

## Operation
- Grant: at most one of if_gnt/d_gnt per cycle, combinational from requests and rr_last flag. Single requester always granted. Both requesting: grant the port not granted last; rr_last updates on every grant.
- Transaction fires on a rising edge with req&gnt. Only then does the requester change fields.
- Address: mem_raddr = mem_waddr = {addr[31:2],2'b00} of the granted port; off = d_addr[1:0].
- Alignment error: half with off[0]=1, word with off≠0, or d_size=11. Request is granted, mem_wr=0, response has d_err=1, d_rdata=0.
- Store: byte mem_wdata={4{d_wdata[7:0]}}, mem_wr=0001<<off. Half {2{d_wdata[15:0]}}, mem_wr=0011<<off. Word d_wdata, mem_wr=1111. mem_wr=0 whenever no granted legal store.
- Load: byte mem_rdata[8*off+:8], half mem_rdata[8*off+:16], word unchanged. Sign-extend unless d_unsigned.
- Response pipeline: RD_LATENCY-deep shift register of tag {valid, port, we, size, unsigned, off, err}. Exactly one response per grant, in grant order, RD_LATENCY cycles after the firing edge. if_rvalid and d_rvalid are never blocked; requesters always accept.
- A store followed by a load of the same word on the next grant returns the new data; the memory writes on the grant edge.

## Timing
- Reset: if_gnt, d_gnt, mem_wr forced 0 while Reset high. rr_last = data, so the first conflict goes to fetch. Tag pipeline cleared; if_rvalid, d_rvalid, d_err = 0; rdata outputs 0.
- Reset mid-flight: in-flight responses are dropped; no rvalid appears after Reset deasserts until new grants.
- Throughput: one grant per cycle, sustained. Under continuous conflict, ports alternate (50/50).
- Latency: grant at edge N gives rvalid during cycle N+RD_LATENCY; gnt→rvalid registered, no combinational path from mem_rdata to grant.

## Configuration
- MEM_PORT_CTRL_STATS_EN defined: adds outputs stat_if_grants[31:0], stat_d_grants[31:0] and stat_conflicts[31:0]. The first two count fired grants per port; stat_conflicts counts cycles with both requests high. All reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package mem_port_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL), resp_tag_t struct, PORT_IF/PORT_D constants.
- Sub-module mem_load_align: combinational lane extract plus sign/zero extension (size, unsigned, off, word → 32-bit result).

## Test plan
- Reset with both reqs high → no gnt, mem_wr=0000. After release, first conflict grants fetch, next cycle grants data.
- SB 0x000000AB to 0x103 → mem_waddr=0x100, mem_wr=1000, mem_wdata=0xABABABAB. LB 0x103 → d_rdata=0xFFFFFFAB; LBU → 0x000000AB.
- SH 0x8001 to 0x102 → mem_wr=1100. LH 0x102 → 0xFFFF8001, LHU → 0x00008001. SW 0x12345678 to 0x100, then LW → 0x12345678.
- LW at 0x101 and SH at 0x103 → granted, mem_wr=0000, d_rvalid with d_err=1, d_rdata=0. d_size=11 errors the same way.
- Both ports requesting for 10 cycles → 5 grants each, alternating. Responses in grant order, each exactly RD_LATENCY cycles later (run RD_LATENCY=1 and 2).
- Reset pulse one cycle after a load grant → no d_rvalid for that load. With MEM_PORT_CTRL_STATS_EN, counters read 0 after reset.
